// File: rtl/arr_bank_pkg.sv
// Shared types and constants for the arr register-array bank arbiter.
// Imported by the arbiter top and any bench component that needs the FSM encoding.
package arr_bank_pkg;

    localparam int ARR_BANK_MAX_IDX = 128;
    localparam int ARR_BANK_DATA_W  = 128;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

endpackage : arr_bank_pkg

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping modulo NREQ.
// Generic so that other arbiters can reuse it.
module rr_pick #(
    parameter int NREQ  = 4,
    parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_gnt_oh,
    output logic [PTR_W-1:0] o_gnt_idx,
    output logic             o_gnt_vld
);

    localparam logic [PTR_W:0] NREQ_W = (PTR_W+1)'(NREQ);

    logic [PTR_W:0]   w_sum;
    logic [PTR_W-1:0] w_cand;
    logic             w_found;

    // NOTE: every output gets a default before the search loop, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        o_gnt_oh  = '0;
        o_gnt_idx = '0;
        w_found   = 1'b0;
        w_sum     = '0;
        w_cand    = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_sum = {1'b0, i_ptr} + (PTR_W+1)'(i);
            if (w_sum >= NREQ_W) begin
                w_sum = w_sum - NREQ_W;
            end
            w_cand = w_sum[PTR_W-1:0];
            if (!w_found && i_req[w_cand]) begin
                w_found          = 1'b1;
                o_gnt_idx        = w_cand;
                o_gnt_oh[w_cand] = 1'b1;
            end
        end
        o_gnt_vld = w_found;
    end

endmodule : rr_pick

// File: rtl/arr_bank_arb.sv
// Round-robin arbiter and access sequencer in front of the arr register-array bank.
// One transaction at a time: IDLE -> ARB -> (ISSUE -> [WAIT]) -> RESP -> IDLE.
module arr_bank_arb
    import arr_bank_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int IDX_W   = 8,
    parameter int MAX_IDX = ARR_BANK_MAX_IDX,
    parameter int DATA_W  = ARR_BANK_DATA_W,
    parameter int TMO     = 16
) (
    input  logic                   arr_bank_arb_clk_ip,
    input  logic                   arr_bank_arb_rst_ip,
    input  logic [NREQ-1:0]        req_ip,
    input  logic [NREQ-1:0]        we_ip,
    input  logic [NREQ*IDX_W-1:0]  idx_ip,
    input  logic [NREQ*DATA_W-1:0] wdata_ip,
    output logic [NREQ-1:0]        ack_op,
    output logic                   err_op,
    output logic [DATA_W-1:0]      rdata_op,
    output logic                   bank_vld_op,
    output logic                   bank_we_op,
    output logic [IDX_W-1:0]       bank_idx_op,
    output logic [DATA_W-1:0]      bank_wdata_op,
    input  logic                   bank_rdy_ip,
    input  logic                   bank_rvld_ip,
    input  logic [DATA_W-1:0]      bank_rdata_ip,
    output logic                   busy_op
);

    localparam int PTR_W = $clog2(NREQ);
    localparam int TMO_W = $clog2(TMO + 1);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO - 1);
    localparam logic [TMO_W-1:0] TMO_SAT  = TMO_W'(TMO);
    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(MAX_IDX);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NREQ - 1);

    arb_state_t r_state;
    arb_state_t w_state_nxt;

    logic [PTR_W-1:0]  r_rr_ptr;
    logic [PTR_W-1:0]  r_gnt;
    logic              r_we;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic [TMO_W-1:0]  r_tmo_cnt;

    logic [IDX_W-1:0]  w_idx_arr   [NREQ];
    logic [DATA_W-1:0] w_wdata_arr [NREQ];
    logic [NREQ-1:0]   w_pick_oh;
    logic [PTR_W-1:0]  w_pick_idx;
    logic              w_pick_vld;
    logic              w_pick_we;
    logic [IDX_W-1:0]  w_pick_bank_idx;
    logic              w_idx_ok;
    logic              w_tmo_hit;
    logic              w_in_issue;

    // Unpack the per-requester buses so the winner can be selected by index.
    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign w_idx_arr[g]   = idx_ip[g*IDX_W +: IDX_W];
        assign w_wdata_arr[g] = wdata_ip[g*DATA_W +: DATA_W];
    end

    rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .i_req     (req_ip),
        .i_ptr     (r_rr_ptr),
        .o_gnt_oh  (w_pick_oh),
        .o_gnt_idx (w_pick_idx),
        .o_gnt_vld (w_pick_vld)
    );

    assign w_pick_we       = |(we_ip & w_pick_oh);
    assign w_pick_bank_idx = w_idx_arr[w_pick_idx];
    assign w_idx_ok        = (w_pick_bank_idx != '0) && (w_pick_bank_idx <= IDX_MAX);
    // The counter reads 0 on the first cycle of a state, so the last allowed cycle is TMO-1.
    assign w_tmo_hit       = (r_tmo_cnt >= TMO_LAST);

    always_ff @(posedge arr_bank_arb_clk_ip or negedge arr_bank_arb_rst_ip) begin
        if (!arr_bank_arb_rst_ip) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (|req_ip) begin
                    w_state_nxt = ARB;
                end
            end
            ARB: begin
                // A requester that withdrew between IDLE and ARB leaves nothing to grant.
                if (!w_pick_vld) begin
                    w_state_nxt = IDLE;
                end else if (!w_idx_ok) begin
                    w_state_nxt = RESP;
                end else begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (bank_rdy_ip) begin
                    w_state_nxt = r_we ? RESP : WAIT;
                end else if (w_tmo_hit) begin
                    w_state_nxt = RESP;
                end
            end
            WAIT: begin
                if (bank_rvld_ip || w_tmo_hit) begin
                    w_state_nxt = RESP;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge arr_bank_arb_clk_ip or negedge arr_bank_arb_rst_ip) begin
        if (!arr_bank_arb_rst_ip) begin
            r_rr_ptr  <= '0;
            r_gnt     <= '0;
            r_we      <= 1'b0;
            r_idx     <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_tmo_cnt <= '0;
        end else begin
            if (w_state_nxt != r_state) begin
                r_tmo_cnt <= '0;
            end else if (r_tmo_cnt != TMO_SAT) begin
                r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            end

            case (r_state)
                ARB: begin
                    if (w_pick_vld) begin
                        r_gnt    <= w_pick_idx;
                        r_we     <= w_pick_we;
                        r_idx    <= w_pick_bank_idx;
                        r_wdata  <= w_wdata_arr[w_pick_idx];
                        r_rr_ptr <= (w_pick_idx == PTR_LAST) ? '0 : w_pick_idx + PTR_W'(1);
                        r_err    <= !w_idx_ok;
                        if (!w_idx_ok && !w_pick_we) begin
                            r_rdata <= '0;
                        end
                    end
                end
                ISSUE: begin
                    if (!bank_rdy_ip && w_tmo_hit) begin
                        r_err <= 1'b1;
                        if (!r_we) begin
                            r_rdata <= '0;
                        end
                    end
                end
                WAIT: begin
                    if (bank_rvld_ip) begin
                        r_rdata <= bank_rdata_ip;
                    end else if (w_tmo_hit) begin
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Command fields are gated with ISSUE so the bank port reads all-zero when idle.
    assign w_in_issue    = (r_state == ISSUE);
    assign bank_vld_op   = w_in_issue;
    assign bank_we_op    = w_in_issue && r_we;
    assign bank_idx_op   = w_in_issue ? r_idx : '0;
    assign bank_wdata_op = w_in_issue ? r_wdata : '0;

    assign err_op   = (r_state == RESP) && r_err;
    assign rdata_op = r_rdata;
    assign busy_op  = (r_state != IDLE);

    always_comb begin
        ack_op = '0;
        if (r_state == RESP) begin
            ack_op[r_gnt] = 1'b1;
        end
    end

endmodule : arr_bank_arb

// File: tb/tb_arr_bank_arb.sv
// Directed bench for arr_bank_arb: a table of single transactions with a reactive bank
// model, plus hand-written fairness, late-rvld and reset-in-WAIT sequences.
module tb_arr_bank_arb;

    localparam int NREQ   = 4;
    localparam int IDX_W  = 8;
    localparam int DATA_W = 128;
    localparam int TMO    = 16;
    localparam int NEVER  = -1;
    localparam int BUDGET = 80;

    logic                   clk   = 1'b0;
    logic                   rst_n = 1'b0;
    logic [NREQ-1:0]        req_ip        = '0;
    logic [NREQ-1:0]        we_ip         = '0;
    logic [NREQ*IDX_W-1:0]  idx_ip        = '0;
    logic [NREQ*DATA_W-1:0] wdata_ip      = '0;
    logic                   bank_rdy_ip   = 1'b0;
    logic                   bank_rvld_ip  = 1'b0;
    logic [DATA_W-1:0]      bank_rdata_ip = '0;
    logic [NREQ-1:0]        ack_op;
    logic                   err_op;
    logic [DATA_W-1:0]      rdata_op;
    logic                   bank_vld_op;
    logic                   bank_we_op;
    logic [IDX_W-1:0]       bank_idx_op;
    logic [DATA_W-1:0]      bank_wdata_op;
    logic                   busy_op;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int           r;
        bit           we;
        logic [7:0]   idx;
        logic [127:0] wdata;
        int           rdy_dly;     // vld cycles before rdy rises, NEVER = stays low
        int           rvld_dly;    // cycles from accept to rvld, NEVER = no rvld
        logic [127:0] bank_rdata;
        bit           exp_err;
        bit           chk_rdata;
        logic [127:0] exp_rdata;
        int           exp_lat;     // req cycle = 1, ack cycle = exp_lat
        int           exp_vld;     // number of cycles bank_vld_op is high
    } vec_t;

    arr_bank_arb #(
        .NREQ    (NREQ),
        .IDX_W   (IDX_W),
        .MAX_IDX (128),
        .DATA_W  (DATA_W),
        .TMO     (TMO)
    ) dut (
        .arr_bank_arb_clk_ip (clk),
        .arr_bank_arb_rst_ip (rst_n),
        .req_ip              (req_ip),
        .we_ip               (we_ip),
        .idx_ip              (idx_ip),
        .wdata_ip            (wdata_ip),
        .ack_op              (ack_op),
        .err_op              (err_op),
        .rdata_op            (rdata_op),
        .bank_vld_op         (bank_vld_op),
        .bank_we_op          (bank_we_op),
        .bank_idx_op         (bank_idx_op),
        .bank_wdata_op       (bank_wdata_op),
        .bank_rdy_ip         (bank_rdy_ip),
        .bank_rvld_ip        (bank_rvld_ip),
        .bank_rdata_ip       (bank_rdata_ip),
        .busy_op             (busy_op)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int r, input bit we, input logic [7:0] idx,
                                input logic [127:0] wdata, input int rdy_dly, input int rvld_dly,
                                input logic [127:0] bank_rdata, input bit exp_err,
                                input bit chk_rdata, input logic [127:0] exp_rdata,
                                input int exp_lat, input int exp_vld);
        vec_t v;
        v.r = r; v.we = we; v.idx = idx; v.wdata = wdata;
        v.rdy_dly = rdy_dly; v.rvld_dly = rvld_dly; v.bank_rdata = bank_rdata;
        v.exp_err = exp_err; v.chk_rdata = chk_rdata; v.exp_rdata = exp_rdata;
        v.exp_lat = exp_lat; v.exp_vld = exp_vld;
        return v;
    endfunction

    task automatic set_fields(input int r, input bit we, input logic [7:0] idx,
                              input logic [127:0] wd);
        we_ip[r]                       = we;
        idx_ip[r*IDX_W +: IDX_W]       = idx;
        wdata_ip[r*DATA_W +: DATA_W]   = wd;
    endtask

    // One isolated transaction against a reactive bank model.
    task automatic run_txn(input vec_t v, input string tag);
        int           n;
        int           vld_cnt;
        int           acc_cyc;
        bit           got_ack;
        bit           stable;
        logic [7:0]   cap_idx;
        logic [127:0] cap_wdata;
        logic         cap_we;
        logic [3:0]   ack_val;
        logic         err_val;
        logic [127:0] rdata_val;

        @(posedge clk); #1;
        set_fields(v.r, v.we, v.idx, v.wdata);
        req_ip[v.r]  = 1'b1;
        bank_rdy_ip  = 1'b0;
        bank_rvld_ip = 1'b0;
        n = 1; vld_cnt = 0; acc_cyc = -1; got_ack = 0; stable = 1;
        cap_idx = '0; cap_wdata = '0; cap_we = 1'b0;
        ack_val = '0; err_val = 1'b0; rdata_val = '0;

        while (!got_ack && n < BUDGET) begin
            @(posedge clk); #1;
            n++;
            bank_rdy_ip   = 1'b0;
            bank_rvld_ip  = 1'b0;
            bank_rdata_ip = '0;
            if (bank_vld_op) begin
                if (vld_cnt == 0) begin
                    cap_idx = bank_idx_op; cap_wdata = bank_wdata_op; cap_we = bank_we_op;
                end else if (bank_idx_op !== cap_idx || bank_wdata_op !== cap_wdata ||
                             bank_we_op !== cap_we) begin
                    stable = 0;
                end
                bank_rdy_ip = (v.rdy_dly != NEVER) && (vld_cnt >= v.rdy_dly);
                if (bank_rdy_ip) acc_cyc = n;
                vld_cnt++;
            end
            if (acc_cyc >= 0 && v.rvld_dly != NEVER && n == acc_cyc + v.rvld_dly) begin
                bank_rvld_ip  = 1'b1;
                bank_rdata_ip = v.bank_rdata;
            end
            if (ack_op != '0) begin
                got_ack   = 1;
                ack_val   = ack_op;
                err_val   = err_op;
                rdata_val = rdata_op;
                req_ip[v.r] = 1'b0;
            end
        end
        bank_rdy_ip  = 1'b0;
        bank_rvld_ip = 1'b0;
        req_ip[v.r]  = 1'b0;

        check({tag, " got ack"}, 128'(got_ack), 128'(1));
        check({tag, " ack"}, 128'(ack_val), 128'(4'b0001 << v.r));
        check({tag, " err"}, 128'(err_val), 128'(v.exp_err));
        check({tag, " latency"}, 128'(n), 128'(v.exp_lat));
        check({tag, " vld cycles"}, 128'(vld_cnt), 128'(v.exp_vld));
        if (v.chk_rdata) check({tag, " rdata"}, rdata_val, v.exp_rdata);
        if (v.exp_vld > 0) begin
            check({tag, " bank idx"}, 128'(cap_idx), 128'(v.idx));
            check({tag, " bank we"}, 128'(cap_we), 128'(v.we));
            if (v.we) check({tag, " bank wdata"}, cap_wdata, v.wdata);
            check({tag, " cmd stable"}, 128'(stable), 128'(1));
        end
        @(posedge clk); #1;
        check({tag, " idle after"}, 128'({ack_op, err_op, busy_op}), 128'(0));
    endtask

    vec_t vecs [9];
    vec_t vtmp;
    int   n;
    int   acks;
    bit   bad;
    logic [3:0] ack_seq [6];
    int         ack_cyc [6];

    initial begin
        //          r  we  idx     wdata               rdy    rvld   bank_rdata          err rd  exp_rdata          lat vld
        vecs[0] = mk(0, 1, 8'd5,   128'hA5,            0,     NEVER, 128'h0,             0,  0,  128'h0,            4,  1);
        vecs[1] = mk(1, 0, 8'd128, 128'h0,             0,     3,     128'hDEAD,          0,  1,  128'hDEAD,         7,  1);
        vecs[2] = mk(2, 1, 8'd0,   128'h11,            0,     NEVER, 128'h0,             1,  0,  128'h0,            3,  0);
        vecs[3] = mk(2, 1, 8'd129, 128'h22,            0,     NEVER, 128'h0,             1,  0,  128'h0,            3,  0);
        vecs[4] = mk(3, 1, 8'd1,   128'h3333_4444,     3,     NEVER, 128'h0,             0,  0,  128'h0,            7,  4);
        vecs[5] = mk(0, 1, 8'd20,  128'h55,            NEVER, NEVER, 128'h0,             1,  0,  128'h0,            19, 16);
        vecs[6] = mk(1, 0, 8'd30,  128'h0,             0,     NEVER, 128'h0,             1,  1,  128'h0,            20, 1);
        vecs[7] = mk(2, 0, 8'd64,  128'h0,             0,     1,     128'h1234_5678,     0,  1,  128'h1234_5678,    5,  1);
        vecs[8] = mk(3, 0, 8'd100, 128'h0,             15,    16,    128'hCAFE_F00D_0BAD, 0, 1,  128'hCAFE_F00D_0BAD, 35, 16);

        // Reset values
        #12;
        check("reset ack/err/vld/we/busy", 128'({ack_op, err_op, bank_vld_op, bank_we_op, busy_op}), 128'(0));
        check("reset rdata", rdata_op, 128'(0));
        check("reset bank idx/wdata", {bank_wdata_op[119:0], bank_idx_op}, 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Read timeout followed by a late rvld that must be ignored
        vtmp = mk(3, 0, 8'd9, 128'h0, 0, NEVER, 128'h0, 1, 1, 128'h0, 20, 1);
        run_txn(vtmp, "late");
        bank_rvld_ip  = 1'b1;
        bank_rdata_ip = 128'hBEEF;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            bank_rvld_ip  = 1'b0;
            bank_rdata_ip = '0;
            if (ack_op != '0 || busy_op) bad = 1;
        end
        check("late rvld no ack", 128'(bad), 128'(0));
        check("late rvld rdata held", rdata_op, 128'(0));

        // Fairness: all requesters held, writes, rdy high
        for (int i = 0; i < 6; i++) begin
            ack_seq[i] = '0;
            ack_cyc[i] = 0;
        end
        @(posedge clk); #1;
        for (int r = 0; r < NREQ; r++) set_fields(r, 1'b1, 8'(10 + r), 128'(r + 1));
        req_ip      = '1;
        bank_rdy_ip = 1'b1;
        n = 1; acks = 0;
        while (acks < 6 && n < BUDGET) begin
            @(posedge clk); #1;
            n++;
            if (ack_op != '0) begin
                ack_seq[acks] = ack_op;
                ack_cyc[acks] = n;
                acks++;
                if (acks == 6) req_ip = '0;
            end
        end
        req_ip      = '0;
        bank_rdy_ip = 1'b0;
        check("fair ack count", 128'(acks), 128'(6));
        for (int i = 0; i < 6; i++) begin
            check($sformatf("fair ack %0d", i), 128'(ack_seq[i]), 128'(4'b0001 << (i % NREQ)));
            check($sformatf("fair cycle %0d", i), 128'(ack_cyc[i]), 128'(4 * (i + 1)));
        end

        // Table of single transactions
        for (int k = 0; k < 9; k++) begin
            run_txn(vecs[k], $sformatf("v%0d", k));
        end

        // Reset while a read sits in WAIT
        @(posedge clk); #1;
        set_fields(1, 1'b0, 8'd7, 128'h0);
        req_ip[1]   = 1'b1;
        bank_rdy_ip = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        bank_rdy_ip = 1'b0;
        check("in wait before reset", 128'({busy_op, bank_vld_op, ack_op}), 128'(6'b10_0000));
        check("rdata before reset", rdata_op, 128'hCAFE_F00D_0BAD);
        #2;
        rst_n  = 1'b0;
        req_ip = '0;
        #1;
        check("mid reset ack/err/vld/we/busy", 128'({ack_op, err_op, bank_vld_op, bank_we_op, busy_op}), 128'(0));
        check("mid reset rdata", rdata_op, 128'(0));
        check("mid reset bank idx/wdata", {bank_wdata_op[119:0], bank_idx_op}, 128'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bank_rvld_ip  = 1'b1;
        bank_rdata_ip = 128'h77;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            bank_rvld_ip  = 1'b0;
            bank_rdata_ip = '0;
            if (ack_op != '0 || busy_op) bad = 1;
        end
        check("post reset no ack", 128'(bad), 128'(0));

        // After reset the pointer is 0: with req0 and req3 both up, 0 wins first
        @(posedge clk); #1;
        set_fields(0, 1'b1, 8'd40, 128'h40);
        set_fields(3, 1'b1, 8'd43, 128'h43);
        req_ip      = 4'b1001;
        bank_rdy_ip = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ack_seq[i] = '0;
            ack_cyc[i] = 0;
        end
        n = 1; acks = 0;
        while (acks < 2 && n < BUDGET) begin
            @(posedge clk); #1;
            n++;
            if (ack_op != '0) begin
                ack_seq[acks] = ack_op;
                ack_cyc[acks] = n;
                acks++;
                req_ip = req_ip & ~ack_op;
                if (err_op) bad = 1;
            end
        end
        req_ip      = '0;
        bank_rdy_ip = 1'b0;
        check("post reset first ack", 128'(ack_seq[0]), 128'(4'b0001));
        check("post reset first latency", 128'(ack_cyc[0]), 128'(4));
        check("post reset second ack", 128'(ack_seq[1]), 128'(4'b1000));
        check("post reset second latency", 128'(ack_cyc[1]), 128'(8));
        check("post reset no err", 128'(bad), 128'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_arr_bank_arb

// File: doc/arr_bank_arb.md
Name: arr_bank_arb

Overview:
- Round-robin arbiter and access sequencer sharing the single access port of the duv register-array bank (arr instances indexed 1..128) between NREQ requesters (test agents, sim control, python-side proxy).
- Sits between the requesters and the bank wrapper, in the duv clock domain.
- Serialises read/write transactions and returns read data, completion and error status to the granted requester.

Parameters:
- NREQ, 4, number of requesters (2..8)
- IDX_W, 8, bank index width
- MAX_IDX, 128, highest legal index; legal range is 1..MAX_IDX
- DATA_W, 128, data width, equal to the widest arr instance
- TMO, 16, cycles to wait for a bank response before aborting with an error

Ports:
- arr_bank_arb_clk_ip  in  1  clock
- arr_bank_arb_rst_ip  in  1  asynchronous active-low reset
- req_ip  in  NREQ  per-requester request, held high until ack
- we_ip  in  NREQ  per-requester write enable: 1 = write, 0 = read
- idx_ip  in  NREQ*IDX_W  packed per-requester index; requester r occupies bits [r*IDX_W +: IDX_W]
- wdata_ip  in  NREQ*DATA_W  packed per-requester write data
- ack_op  in/out: out  NREQ  one-hot, 1-cycle completion pulse
- err_op  out  1  valid only with ack; 1 = bad index or timeout
- rdata_op  out  DATA_W  read data, valid with ack on a read
- bank_vld_op  out  1  bank command valid
- bank_we_op  out  1  bank command is a write
- bank_idx_op  out  IDX_W  bank command index
- bank_wdata_op  out  DATA_W  bank write data
- bank_rdy_ip  in  1  bank accepts the command when bank_vld_op && bank_rdy_ip
- bank_rvld_ip  in  1  read data valid, 1-cycle pulse
- bank_rdata_ip  in  DATA_W  read data
- busy_op  out  1  FSM not in IDLE

Behaviour:
- Reset (async assert, sync deassert handled by the caller) drives:
  - FSM to IDLE; rr_ptr = 0.
  - All outputs to 0: ack_op, err_op, rdata_op, bank_* and busy_op.
- Reset mid-transaction abandons it silently; no ack is issued.
- FSM states:
  - IDLE: if any req_ip is set, go to ARB.
  - ARB (1 cycle):
    - Pick the first set req_ip at or after rr_ptr, wrapping modulo NREQ.
    - Latch gnt, we, idx and wdata.
    - Set rr_ptr = gnt+1 mod NREQ.
    - If idx==0 or idx>MAX_IDX, go to RESP with err=1 and no bank command; otherwise go to ISSUE.
  - ISSUE:
    - Drive bank_vld_op=1 with the latched we/idx/wdata, held stable until bank_rdy_ip.
    - On accept, a write goes to RESP (err=0) and a read goes to WAIT.
    - tmo_cnt runs from entry; reaching TMO with no accept goes to RESP with err=1 and drops bank_vld_op.
  - WAIT:
    - bank_rvld_ip captures bank_rdata_ip and goes to RESP with err=0.
    - TMO cycles with no rvld go to RESP with err=1 and rdata=0.
    - A late rvld arriving after the timeout is ignored.
  - RESP (1 cycle): ack_op[gnt]=1, err_op and rdata_op valid; then go to IDLE.
- rdata_op holds its value until the next read RESP; err_op is 0 outside RESP.
- tmo_cnt is $clog2(TMO+1) bits wide, clears on every state change, and saturates.
- Latency:
  - Minimum write: req to ack = 4 cycles (IDLE, ARB, ISSUE, RESP) with rdy already high.
  - Minimum read: 5 cycles with rvld in the cycle after accept.
- A requester dropping req before its ack is a protocol violation. The latched transaction still completes and the ack pulses regardless.
- Requests arriving during a transaction wait; no queueing beyond the input levels.
- bank_rvld_ip outside WAIT is ignored.
- Fairness: with all requesters held high, grants rotate 0,1,..,NREQ-1,0, so each requester waits at most NREQ-1 transactions.

Decomposition:
- Shared package arr_bank_pkg holds:
  - FSM state enum {IDLE, ARB, ISSUE, WAIT, RESP}
  - constants ARR_BANK_MAX_IDX=128, ARR_BANK_DATA_W=128
- Sub-module rr_pick (combinational):
  - inputs: req vector, ptr
  - outputs: one-hot grant and its encoded index
  - parameterised by NREQ and reusable by other arbiters in the bench.

Test Plan:
- Single write: req0, we=1, idx=5, wdata=0xA5, rdy tied high → bank_vld for 1 cycle carrying idx=5/0xA5; ack_op=0001 at cycle 4; err=0.
- Read with 3-cycle bank delay: req1, idx=128 → bank accept, rvld 3 cycles later with 0xDEAD → ack_op=0010, rdata_op=0xDEAD, err=0.
- Bad index:
  - req2 with idx=0 → ack_op=0100, err=1, bank_vld never set.
  - Repeat with idx=129 → same response.
- Fairness: all four reqs held, writes, rdy high → ack order 0,1,2,3,0,1 with no requester skipped; rr_ptr wraps from 3 to 0.
- Timeouts, TMO=16:
  - rdy held low → ack with err=1 after exactly 16 ISSUE cycles.
  - Read with rvld never asserted → err=1, rdata=0.
  - A late rvld afterwards → no ack.
- Reset in WAIT: assert rst low mid-read → all outputs 0 immediately, no ack; after release a new req3 write completes normally with rr_ptr starting at 0.
